// File: rtl/memory_access_pkg.sv
// ============================================================================
// memory_access_pkg
// Shared constants and types for the MEM stage of the MIPS datapath. The
// address, PC and register-index widths are common with Decode and Execute.
// Contents:
//   ADDR_BITS  - word-address width of the data memory (2^ADDR_BITS words)
//   PC_WIDTH   - width of the PC / branch target
//   REG_BITS   - register-index width
//   mem_wb_t   - MEM/WB pipeline register contents
//   word_index - byte address -> data memory word index
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package memory_access_pkg;

  localparam int ADDR_BITS  = 8;
  localparam int PC_WIDTH   = 10;
  localparam int REG_BITS   = 5;
  localparam int DATA_WIDTH = 32;

  // Everything that travels to write-back except the load data, which is
  // registered inside the RAM.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_result;
    logic [REG_BITS-1:0]   wr;
    logic                  reg_write;
    logic                  mem_to_reg;
  } mem_wb_t;

  // Upper byte-address bits are dropped, so out-of-range addresses wrap.
  function automatic logic [ADDR_BITS-1:0] word_index(input logic [DATA_WIDTH-1:0] byte_addr);
    return byte_addr[ADDR_BITS+1:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/memory_access_if.sv
// ============================================================================
// memory_access_if
// Bundle between Execute and the MEM stage, plus the MEM/WB outputs feeding
// write-back and the branch outputs feeding fetch.
// Modports:
//   master - the Execute side / environment: drives instruction fields,
//            observes the stage outputs
//   slave  - the memory_access stage
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface memory_access_if;
  import memory_access_pkg::*;

  // From Execute
  logic [PC_WIDTH-1:0]   inPC;
  logic                  zero;
  logic [DATA_WIDTH-1:0] aluResult;
  logic [DATA_WIDTH-1:0] inData2;
  logic [REG_BITS-1:0]   inWr;
  logic                  branch;
  logic                  memRead;
  logic                  memWrite;
  logic                  inRegWrite;
  logic                  inMemToReg;

  // To fetch (combinational)
  logic                  pcSrc;
  logic [PC_WIDTH-1:0]   branchPC;

  // To write-back (registered)
  logic [DATA_WIDTH-1:0] readData;
  logic [DATA_WIDTH-1:0] outAluResult;
  logic [REG_BITS-1:0]   outWr;
  logic                  outRegWrite;
  logic                  outMemToReg;
  logic                  misaligned;

  modport master (
    output inPC, zero, aluResult, inData2, inWr,
           branch, memRead, memWrite, inRegWrite, inMemToReg,
    input  pcSrc, branchPC, readData, outAluResult, outWr,
           outRegWrite, outMemToReg, misaligned
  );

  modport slave (
    input  inPC, zero, aluResult, inData2, inWr,
           branch, memRead, memWrite, inRegWrite, inMemToReg,
    output pcSrc, branchPC, readData, outAluResult, outWr,
           outRegWrite, outMemToReg, misaligned
  );

endinterface

`default_nettype wire

// File: rtl/memory_access_data_memory.sv
// ============================================================================
// data_memory
// Falling-edge synchronous single-port data RAM with write enable and
// write-first read. Contents are never cleared; only the read register resets.
// Ports:
//   clock      - stage clock (falling-edge active)
//   reset      - asynchronous active-low reset (read register only)
//   we         - write enable
//   re         - read enable; read register holds when low
//   addr       - word index
//   wdata      - write data
//   rdata      - registered read data
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  input  wire logic                  we,
  input  wire logic                  re,
  input  wire logic [ADDR_BITS-1:0]  addr,
  input  wire logic [DATA_WIDTH-1:0] wdata,
  output      logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Array kept out of the reset domain so it maps onto a plain RAM; the
  // reset level still blocks stores while reset is held.
  always_ff @(negedge clock) begin
    if (reset && we) begin
      mem[addr] <= wdata;
    end
  end

  // Write-first: a simultaneous read returns the data being written.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/memory_access.sv
// ============================================================================
// memory_access
// MEM stage of the MIPS datapath: data-memory load/store, branch resolution
// back to fetch, and the MEM/WB pipeline register. All state updates on the
// falling edge of clock; reset is asynchronous active-low.
// Ports:
//   clock  - stage clock
//   reset  - asynchronous active-low reset
//   bus    - memory_access_if.slave (Execute inputs, fetch and WB outputs)
// Build option:
//   MEM_MISALIGN_TRAP_EN - when defined, loads/stores with aluResult[1:0]!=0
//                          are suppressed (load returns 0, regWrite dropped)
//                          and the sticky misaligned flag is set. When
//                          undefined, the low address bits are ignored and
//                          misaligned is tied to 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_access
  import memory_access_pkg::*;
(
  input  wire logic     clock,
  input  wire logic     reset,
  memory_access_if.slave bus
);

  logic                  access_misaligned;
  logic                  load_trap;
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_BITS-1:0]  ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  mem_wb_t               mem_wb;

  // --------------------------------------------------------------------------
  // Branch resolution: not registered, fetch samples it on the capture edge.
  // --------------------------------------------------------------------------
  assign bus.pcSrc    = reset & bus.branch & bus.zero;
  assign bus.branchPC = bus.inPC;

  // --------------------------------------------------------------------------
  // Misalignment detection
  // --------------------------------------------------------------------------
`ifdef MEM_MISALIGN_TRAP_EN
  assign access_misaligned = (bus.memRead | bus.memWrite) & (bus.aluResult[1:0] != 2'b00);
`else
  assign access_misaligned = 1'b0;
`endif

  assign load_trap = bus.memRead & access_misaligned;

  // --------------------------------------------------------------------------
  // Data memory
  // --------------------------------------------------------------------------
  assign ram_addr = word_index(bus.aluResult);
  assign ram_we   = bus.memWrite & ~access_misaligned;
  assign ram_re   = bus.memRead  & ~access_misaligned;

  data_memory #(
    .ADDR_BITS  (ADDR_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_data_memory (
    .clock (clock),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (bus.inData2),
    .rdata (ram_rdata)
  );

  // --------------------------------------------------------------------------
  // Load data and sticky flag
  // --------------------------------------------------------------------------
`ifdef MEM_MISALIGN_TRAP_EN
  logic load_zeroed;
  logic sticky_misaligned;

  // A trapped load leaves the RAM read register untouched; this bit masks it
  // so readData shows 0 until the next load updates the selection.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      load_zeroed       <= 1'b0;
      sticky_misaligned <= 1'b0;
    end else begin
      if (bus.memRead) begin
        load_zeroed <= access_misaligned;
      end
      if (access_misaligned) begin
        sticky_misaligned <= 1'b1;
      end
    end
  end

  assign bus.readData   = load_zeroed ? '0 : ram_rdata;
  assign bus.misaligned = sticky_misaligned;
`else
  assign bus.readData   = ram_rdata;
  assign bus.misaligned = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // MEM/WB pipeline register: loads every falling edge, no enable.
  // --------------------------------------------------------------------------
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      mem_wb <= '0;
    end else begin
      mem_wb.alu_result <= bus.aluResult;
      mem_wb.wr         <= bus.inWr;
      mem_wb.reg_write  <= bus.inRegWrite & ~load_trap;
      mem_wb.mem_to_reg <= bus.inMemToReg;
    end
  end

  assign bus.outAluResult = mem_wb.alu_result;
  assign bus.outWr        = mem_wb.wr;
  assign bus.outRegWrite  = mem_wb.reg_write;
  assign bus.outMemToReg  = mem_wb.mem_to_reg;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
// ============================================================================
// tb_memory_access
// Self-checking bench for memory_access: a word-array model of the stage,
// a per-cycle compare process, and directed vectors with literal checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_access;
  import memory_access_pkg::*;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clock = 1'b1;
  logic reset = 1'b1;

  // Falling edges at 5,15,25...; rising edges at 10,20,30...
  always #5 clock = ~clock;

  memory_access_if bus ();

  memory_access dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: memory as a word array, outputs computed from the stage rules.
  // --------------------------------------------------------------------------
  logic [31:0] m_mem   [256];
  bit          m_known [256];
  logic [31:0] e_rd    = '0;
  bit          e_rd_ok = 1'b1;
  logic [31:0] e_alu   = '0;
  logic [4:0]  e_wr    = '0;
  logic        e_rw    = 1'b0;
  logic        e_m2r   = 1'b0;
  logic        e_mis   = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
  end

  always @(negedge clock or negedge reset) begin : model
    int idx;
    bit bad;
    if (!reset) begin
      e_rd = '0; e_rd_ok = 1'b1; e_alu = '0; e_wr = '0;
      e_rw = 1'b0; e_m2r = 1'b0; e_mis = 1'b0;
    end else begin
      idx = int'((bus.aluResult / 4) % 256);
      bad = TRAP && (bus.aluResult % 4 != 0) && (bus.memRead || bus.memWrite);
      if (bus.memWrite && !bad) begin
        m_mem[idx]   = bus.inData2;
        m_known[idx] = 1'b1;
      end
      if (bus.memRead) begin
        if (bad) begin
          e_rd = '0; e_rd_ok = 1'b1;
        end else begin
          e_rd = m_mem[idx]; e_rd_ok = m_known[idx];
        end
      end
      e_alu = bus.aluResult;
      e_wr  = bus.inWr;
      e_rw  = bus.inRegWrite && !(bad && bus.memRead);
      e_m2r = bus.inMemToReg;
      if (bad) e_mis = 1'b1;
    end
  end

  // Compare on the rising edge, half a cycle from the capture edge.
  always @(posedge clock) begin
    chk("outAluResult", bus.outAluResult, e_alu);
    chk("outWr", 32'(bus.outWr), 32'(e_wr));
    chk("outRegWrite", 32'(bus.outRegWrite), 32'(e_rw));
    chk("outMemToReg", 32'(bus.outMemToReg), 32'(e_m2r));
    chk("misaligned", 32'(bus.misaligned), 32'(e_mis));
    if (e_rd_ok) chk("readData", bus.readData, e_rd);
    chk("pcSrc", 32'(bus.pcSrc), 32'(reset && bus.branch && bus.zero));
    chk("branchPC", 32'(bus.branchPC), 32'(bus.inPC));
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic set_in(input logic [31:0] alu, input logic [31:0] data, input logic [4:0] wr,
                        input logic br, input logic zr, input logic [9:0] pc,
                        input logic mr, input logic mw, input logic rw, input logic m2r);
    bus.aluResult  = alu;
    bus.inData2    = data;
    bus.inWr       = wr;
    bus.branch     = br;
    bus.zero       = zr;
    bus.inPC       = pc;
    bus.memRead    = mr;
    bus.memWrite   = mw;
    bus.inRegWrite = rw;
    bus.inMemToReg = m2r;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] data, input logic [4:0] wr,
                       input logic br, input logic zr, input logic [9:0] pc,
                       input logic mr, input logic mw, input logic rw, input logic m2r);
    @(posedge clock);
    #2;
    set_in(alu, data, wr, br, zr, pc, mr, mw, rw, m2r);
  endtask

  task automatic bubble();
    drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic after_capture();
    @(negedge clock);
    #1;
  endtask

  initial begin
    set_in(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;

    // Reset held with random inputs
    repeat (3) begin
      @(posedge clock);
      #2;
      set_in($urandom, $urandom, 5'($urandom), 1'b1, 1'b1, 10'($urandom),
             1'($urandom), 1'($urandom), 1'b1, 1'b1);
    end
    after_capture();
    chk("rst_readData", bus.readData, 32'd0);
    chk("rst_outAluResult", bus.outAluResult, 32'd0);
    chk("rst_outRegWrite", 32'(bus.outRegWrite), 32'd0);
    chk("rst_pcSrc", 32'(bus.pcSrc), 32'd0);

    // Release, store then load
    drive(32'd16, 32'hDEADBEEF, 5'd7, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    after_capture();
    chk("first_outAluResult", bus.outAluResult, 32'd16);
    chk("first_outWr", 32'(bus.outWr), 32'd7);
    drive(32'd16, 32'd0, 5'd9, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    after_capture();
    chk("load16_readData", bus.readData, 32'hDEADBEEF);
    chk("load16_outAluResult", bus.outAluResult, 32'd16);
    chk("load16_outWr", 32'(bus.outWr), 32'd9);

    // Wrap-around
    drive(32'd4, 32'h1234, 5'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(32'd1028, 32'd0, 5'd3, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    after_capture();
    chk("wrap_readData", bus.readData, 32'h1234);

    // Branch
    drive(32'd0, 32'd0, 5'd0, 1'b1, 1'b1, 10'd514, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("branch_taken_pcSrc", 32'(bus.pcSrc), 32'd1);
    chk("branch_branchPC", 32'(bus.branchPC), 32'd514);
    drive(32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 10'd514, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("branch_nottaken_pcSrc", 32'(bus.pcSrc), 32'd0);

    // Write-first, then hold, then reload
    drive(32'd8, 32'd30, 5'd4, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    after_capture();
    chk("wf_readData", bus.readData, 32'd30);
    bubble();
    after_capture();
    chk("hold_readData", bus.readData, 32'd30);
    drive(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(32'd8, 32'd0, 5'd4, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    after_capture();
    chk("wf_reload_readData", bus.readData, 32'd30);

    // Reset mid-cycle discards an in-flight store
    drive(32'd40, 32'h5555, 5'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(32'd40, 32'hAAAA, 5'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 reset = 1'b0;
    after_capture();
    chk("midrst_readData", bus.readData, 32'd0);
    bubble();
    reset = 1'b1;
    drive(32'd40, 32'd0, 5'd2, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    after_capture();
    chk("midrst_load40", bus.readData, 32'h5555);

    // Misaligned store to word 4 (holds 0xDEADBEEF)
    drive(32'd18, 32'hFF, 5'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    after_capture();
    chk("mis_store_flag", 32'(bus.misaligned), TRAP ? 32'd1 : 32'd0);
    bubble();
    drive(32'd16, 32'd0, 5'd5, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    after_capture();
    chk("mis_word4", bus.readData, TRAP ? 32'hDEADBEEF : 32'hFF);

    // Misaligned load
    drive(32'd17, 32'd0, 5'd6, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    after_capture();
    chk("mis_load_readData", bus.readData, TRAP ? 32'd0 : 32'hFF);
    chk("mis_load_regWrite", 32'(bus.outRegWrite), TRAP ? 32'd0 : 32'd1);
    bubble();
    bubble();
    after_capture();
    chk("mis_sticky", 32'(bus.misaligned), TRAP ? 32'd1 : 32'd0);

    // Reset clears the flag
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mis_reset_clear", 32'(bus.misaligned), 32'd0);
    bubble();
    reset = 1'b1;
    bubble();
    after_capture();
    chk("mis_after_reset", 32'(bus.misaligned), 32'd0);

    repeat (2) @(posedge clock);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_access.md
# memory_access

Fourth pipeline stage of the MIPS datapath, the consumer of everything the Execute stage produces. It takes the ALU result as a data address, the forwarded second register operand as store data, the destination register and the zero flag. It performs the data-memory load or store, resolves the branch decision back to fetch, and holds the MEM/WB pipeline register that feeds write-back.

## Interface
- `ADDR_BITS`, 8: word-address width; the data memory holds 2^ADDR_BITS 32-bit words.
- `PC_WIDTH`, 10: width of the PC / branch target, matching Execute `outPC`.
- `clock`  in  1  stage clock; all state updates on the falling edge, as in Execute.
- `reset`  in  1  asynchronous, active-low reset.
- `inPC`  in  PC_WIDTH  branch target computed by Execute.
- `zero`  in  1  ALU zero flag from Execute.
- `aluResult`  in  32  byte address for loads/stores; also the pass-through result.
- `inData2`  in  32  store data (Execute `outData2`).
- `inWr`  in  5  destination register (Execute `wr`).
- `branch`, `memRead`, `memWrite`, `inRegWrite`, `inMemToReg`  in  1 each  control bits travelling with the instruction.
- `pcSrc`  out  1  combinational: `branch & zero`; forced 0 while `reset` is low.
- `branchPC`  out  PC_WIDTH  combinational copy of `inPC`.
- `readData`  out  32  registered load data.
- `outAluResult`  out  32  registered `aluResult`.
- `outWr`  out  5  registered `inWr`.
- `outRegWrite`, `outMemToReg`  out  1 each  registered control bits.
- `misaligned`  out  1  sticky misalignment flag (see Configuration).

## Operation
- Word index = `aluResult[ADDR_BITS+1:2]`. Upper address bits are ignored, so an out-of-range address wraps modulo the memory size.
- Store: on a falling edge with `memWrite`=1, `mem[index] <= inData2`.
- Load: on a falling edge with `memRead`=1, `readData <= mem[index]`. With `memRead`=0, `readData` holds its previous value.
- `memRead` and `memWrite` both high: write-first. The memory is written and `readData <= inData2`.
- The MEM/WB register (`outAluResult`, `outWr`, `outRegWrite`, `outMemToReg`) loads every falling edge and carries no enable. A bubble is an instruction with all controls 0.
- `pcSrc` is not registered; fetch samples it on the same edge that captures this stage.
- Reset (asynchronous, `reset`=0):
  - `readData`, `outAluResult`, `outWr`, `outRegWrite`, `outMemToReg` and `misaligned` all go to 0.
  - Memory contents are not cleared.
  - No store occurs while `reset` is low.
  - Reset asserted mid-cycle discards the in-flight access. The first capture after release is the first falling edge with `reset`=1.

## Timing
- Latency: one falling edge from inputs to every registered output. `readData` and `outAluResult` for the same instruction appear together.
- A load to the address written by a store on the immediately preceding edge returns the new data.
- `pcSrc` and `branchPC` settle combinationally within the same half-cycle as their inputs.
- Inputs must be stable from the rising edge to the following falling edge, matching the Execute-stage timing.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A load or store with `aluResult[1:0]` != 0 is misaligned.
  - A misaligned store is suppressed and leaves memory unchanged.
  - A misaligned load captures 0 into `readData` and forces `outRegWrite` to 0.
  - `misaligned` sets to 1 and stays set until `reset`.
- Not defined:
  - `aluResult[1:0]` is ignored and the access proceeds to the aligned word.
  - `misaligned` is tied to 0.

## Structure
- Shared package: `ADDR_BITS`, `PC_WIDTH` and the register-index width (5). These are common with Execute and Decode.
- One sub-module: `data_memory`, the falling-edge synchronous single-port RAM with write-first read and a write enable.
- The pipeline register, branch logic and misalignment logic stay in `memory_access`.

## Test plan
- Reset: hold `reset`=0 with random inputs -> all registered outputs 0 and `pcSrc`=0. Release reset -> first falling edge captures normally.
- Store then load: store `inData2`=0xDEADBEEF at `aluResult`=16. Next cycle load from 16 -> `readData`=0xDEADBEEF. `outAluResult`=16 and `outWr` follows `inWr`.
- Wrap-around: store 0x1234 at address 4, then load from address 4+4·256=1028 -> `readData`=0x1234.
- Branch: `branch`=1 with `zero`=1 and `inPC`=514 -> `pcSrc`=1, `branchPC`=514. With `zero`=0 -> `pcSrc`=0.
- Write-first: `memRead`=`memWrite`=1 with `inData2`=30 at address 8 -> `readData`=30. A later load from 8 also returns 30.
- Misaligned (macro on): store 0xFF to address 18 -> memory word 4 unchanged and `misaligned`=1, sticky until reset. Macro off -> word 4 = 0xFF and `misaligned`=0.
